// File: rtl/ifetch.sv
// Instruction fetch unit: issues Wishbone reads for sequential 8-byte words and
// hands each fetched instruction to decode through a single-entry output buffer.
module ifetch #(
    parameter int                   ADR_WIDTH = 64,
    parameter int                   DAT_WIDTH = 64,
    parameter logic [ADR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    output logic                 fetch_cyc_o,
    output logic                 fetch_stb_o,
    output logic                 fetch_we_o,
    output logic [ADR_WIDTH-1:0] fetch_adr_o,
    input  logic [DAT_WIDTH-1:0] fetch_dat_i,
    input  logic                 fetch_ack_i,
    input  logic                 fetch_err_i,

    output logic [DAT_WIDTH-1:0] instr_o,
    output logic [ADR_WIDTH-1:0] instr_pc_o,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,

    input  logic                 redirect_i,
    input  logic [ADR_WIDTH-1:0] redirect_pc_i,
    input  logic                 halt_i,

    output logic                 fault_o,
    output logic [ADR_WIDTH-1:0] fault_pc_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t               state_reg;
    logic [ADR_WIDTH-1:0] pc_reg;
    logic [ADR_WIDTH-1:0] adr_reg;
    logic                 stb_reg;
    logic [DAT_WIDTH-1:0] instr_reg;
    logic [ADR_WIDTH-1:0] instr_pc_reg;
    logic                 valid_reg;
    logic                 fault_reg;
    logic [ADR_WIDTH-1:0] fault_pc_reg;

    logic redirect_misaligned;
    logic transfer;
    logic can_issue;

    assign redirect_misaligned = |redirect_pc_i[2:0];
    assign transfer            = valid_reg & instr_ready_i;
    // Issue only into an empty buffer, so an ack can never overwrite a held instruction.
    assign can_issue           = ~valid_reg & ~halt_i & ~fault_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            adr_reg      <= RESET_PC;
            stb_reg      <= 1'b0;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            fault_pc_reg <= '0;
        end else if (redirect_i) begin
            // Redirect abandons any in-flight request; its response is never looked at.
            state_reg <= GAP;
            stb_reg   <= 1'b0;
            pc_reg    <= redirect_pc_i;
            valid_reg <= 1'b0;
            fault_reg <= redirect_misaligned;
            if (redirect_misaligned) begin
                fault_pc_reg <= redirect_pc_i;
            end
        end else begin
            if (transfer) begin
                valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (can_issue) begin
                        state_reg <= REQ;
                        stb_reg   <= 1'b1;
                        adr_reg   <= pc_reg;
                    end
                end
                REQ: begin
                    if (fetch_err_i) begin
                        state_reg    <= GAP;
                        stb_reg      <= 1'b0;
                        fault_reg    <= 1'b1;
                        fault_pc_reg <= pc_reg;
                    end else if (fetch_ack_i) begin
                        state_reg    <= GAP;
                        stb_reg      <= 1'b0;
                        instr_reg    <= fetch_dat_i;
                        instr_pc_reg <= pc_reg;
                        valid_reg    <= 1'b1;
                        pc_reg       <= pc_reg + ADR_WIDTH'(8);
                    end
                end
                GAP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    stb_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_cyc_o   = stb_reg;
    assign fetch_stb_o   = stb_reg;
    assign fetch_we_o    = 1'b0;
    assign fetch_adr_o   = adr_reg;
    assign instr_o       = instr_reg;
    assign instr_pc_o    = instr_pc_reg;
    assign instr_valid_o = valid_reg;
    assign fault_o       = fault_reg;
    assign fault_pc_o    = fault_pc_reg;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a cycle-by-cycle vector table from reset, then directed
// sequences for bus error, halt with a stalled slave, address wrap and mid-request reset.
module tb_ifetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_cyc_o;
    logic        fetch_stb_o;
    logic        fetch_we_o;
    logic [63:0] fetch_adr_o;
    logic [63:0] fetch_dat_i;
    logic        fetch_ack_i;
    logic        fetch_err_i;
    logic [63:0] instr_o;
    logic [63:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic        redirect_i    = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        halt_i        = 1'b0;
    logic        fault_o;
    logic [63:0] fault_pc_o;

    // Slave model controls
    logic        ack_en  = 1'b1;
    logic        err_en  = 1'b0;
    logic [63:0] err_adr = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ifetch dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_cyc_o   (fetch_cyc_o),
        .fetch_stb_o   (fetch_stb_o),
        .fetch_we_o    (fetch_we_o),
        .fetch_adr_o   (fetch_adr_o),
        .fetch_dat_i   (fetch_dat_i),
        .fetch_ack_i   (fetch_ack_i),
        .fetch_err_i   (fetch_err_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .fault_o       (fault_o),
        .fault_pc_o    (fault_pc_o)
    );

    function automatic logic [63:0] rom(input logic [63:0] adr);
        case (adr)
            64'h0:   return 64'h0204000000200420;
            64'h8:   return 64'h0208000000001cc0;
            default: return 64'hC0DE000000000000 ^ adr;
        endcase
    endfunction

    // Zero-wait-state slave: acknowledges in the same cycle the strobe is seen.
    logic err_hit;
    assign err_hit     = err_en && (fetch_adr_o == err_adr);
    assign fetch_dat_i = rom(fetch_adr_o);
    assign fetch_ack_i = fetch_stb_o && ack_en && !err_hit;
    assign fetch_err_i = fetch_stb_o && err_hit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_stb(input string name, input int max_cycles);
        int n = 0;
        while (!fetch_stb_o && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (!fetch_stb_o) begin
            errors++;
            $display("FAIL %s: stb=0 after %0d cycles, required 1", name, max_cycles);
        end
    endtask

    task automatic pulse_redirect(input logic [63:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        step();
        redirect_i    = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [63:0] rpc;
        logic        stb;
        logic [63:0] adr;
        logic        valid;
        logic [63:0] ipc;
        logic        fault;
        logic [63:0] fpc;
    } vec_t;

    function automatic vec_t v(input logic ready, input logic redir, input logic [63:0] rpc,
                               input logic stb, input logic [63:0] adr, input logic valid,
                               input logic [63:0] ipc, input logic fault, input logic [63:0] fpc);
        vec_t r;
        r.ready = ready; r.redir = redir; r.rpc = rpc;
        r.stb = stb; r.adr = adr; r.valid = valid; r.ipc = ipc;
        r.fault = fault; r.fpc = fpc;
        return r;
    endfunction

    vec_t vecs[24];

    initial begin
        int stb_seen;
        logic [63:0] held;

        // Expected state after each rising edge following reset release.
        //           rdy rd  rpc     stb adr     val ipc     flt fpc
        vecs[0]  = v(1, 0, 64'h00, 1, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[1]  = v(1, 0, 64'h00, 0, 64'h00, 1, 64'h00, 0, 64'h00);
        vecs[2]  = v(1, 0, 64'h00, 0, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[3]  = v(1, 0, 64'h00, 1, 64'h08, 0, 64'h00, 0, 64'h00);
        vecs[4]  = v(1, 0, 64'h00, 0, 64'h00, 1, 64'h08, 0, 64'h00);
        vecs[5]  = v(1, 0, 64'h00, 0, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[6]  = v(1, 0, 64'h00, 1, 64'h10, 0, 64'h00, 0, 64'h00);
        vecs[7]  = v(1, 1, 64'h18, 0, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[8]  = v(1, 0, 64'h00, 0, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[9]  = v(1, 0, 64'h00, 1, 64'h18, 0, 64'h00, 0, 64'h00);
        vecs[10] = v(1, 0, 64'h00, 0, 64'h00, 1, 64'h18, 0, 64'h00);
        vecs[11] = v(0, 0, 64'h00, 0, 64'h00, 1, 64'h18, 0, 64'h00);
        vecs[12] = v(0, 0, 64'h00, 0, 64'h00, 1, 64'h18, 0, 64'h00);
        vecs[13] = v(1, 0, 64'h00, 0, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[14] = v(1, 0, 64'h00, 1, 64'h20, 0, 64'h00, 0, 64'h00);
        vecs[15] = v(1, 0, 64'h00, 0, 64'h00, 1, 64'h20, 0, 64'h00);
        vecs[16] = v(1, 0, 64'h00, 0, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[17] = v(1, 1, 64'h0C, 0, 64'h00, 0, 64'h00, 1, 64'h0C);
        vecs[18] = v(1, 0, 64'h00, 0, 64'h00, 0, 64'h00, 1, 64'h0C);
        vecs[19] = v(1, 0, 64'h00, 0, 64'h00, 0, 64'h00, 1, 64'h0C);
        vecs[20] = v(1, 1, 64'h00, 0, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[21] = v(1, 0, 64'h00, 0, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[22] = v(1, 0, 64'h00, 1, 64'h00, 0, 64'h00, 0, 64'h00);
        vecs[23] = v(1, 0, 64'h00, 0, 64'h00, 1, 64'h00, 0, 64'h00);

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset stb", {63'd0, fetch_stb_o}, 64'd0);
        chk("reset cyc", {63'd0, fetch_cyc_o}, 64'd0);
        chk("reset we", {63'd0, fetch_we_o}, 64'd0);
        chk("reset adr", fetch_adr_o, 64'd0);
        chk("reset valid", {63'd0, instr_valid_o}, 64'd0);
        chk("reset instr", instr_o, 64'd0);
        chk("reset ipc", instr_pc_o, 64'd0);
        chk("reset fault", {63'd0, fault_o}, 64'd0);
        chk("reset fpc", fault_pc_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 24; i++) begin
            instr_ready_i = vecs[i].ready;
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            step();
            $display("vec %0d: stb=%0b adr=%h valid=%0b ipc=%h fault=%0b",
                     i, fetch_stb_o, fetch_adr_o, instr_valid_o, instr_pc_o, fault_o);
            chk($sformatf("vec%0d stb", i), {63'd0, fetch_stb_o}, {63'd0, vecs[i].stb});
            chk($sformatf("vec%0d cyc", i), {63'd0, fetch_cyc_o}, {63'd0, vecs[i].stb});
            chk($sformatf("vec%0d valid", i), {63'd0, instr_valid_o}, {63'd0, vecs[i].valid});
            chk($sformatf("vec%0d fault", i), {63'd0, fault_o}, {63'd0, vecs[i].fault});
            if (vecs[i].stb)
                chk($sformatf("vec%0d adr", i), fetch_adr_o, vecs[i].adr);
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d ipc", i), instr_pc_o, vecs[i].ipc);
                chk($sformatf("vec%0d instr", i), instr_o, rom(vecs[i].ipc));
            end
            if (vecs[i].fault)
                chk($sformatf("vec%0d fpc", i), fault_pc_o, vecs[i].fpc);
        end
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;

        // Bus error at 0x20: sticky fault, no further strobes, cleared by redirect.
        err_en  = 1'b1;
        err_adr = 64'h20;
        pulse_redirect(64'h20);
        wait_stb("err issue", 8);
        chk("err adr", fetch_adr_o, 64'h20);
        step();
        $display("err seq: fault=%0b fpc=%h stb=%0b", fault_o, fault_pc_o, fetch_stb_o);
        chk("err fault", {63'd0, fault_o}, 64'd1);
        chk("err fpc", fault_pc_o, 64'h20);
        chk("err valid", {63'd0, instr_valid_o}, 64'd0);
        stb_seen = 0;
        repeat (8) begin
            step();
            if (fetch_stb_o) stb_seen++;
        end
        chk("err no stb", 64'(stb_seen), 64'd0);
        err_en = 1'b0;
        pulse_redirect(64'h00);
        chk("err cleared", {63'd0, fault_o}, 64'd0);
        wait_stb("err resume", 8);
        chk("err resume adr", fetch_adr_o, 64'h00);
        step();
        chk("err resume ipc", instr_pc_o, 64'h00);
        chk("err resume instr", instr_o, 64'h0204000000200420);

        // Halt raised while a request is stalled on the bus.
        ack_en = 1'b0;
        pulse_redirect(64'h40);
        wait_stb("halt issue", 8);
        chk("halt adr", fetch_adr_o, 64'h40);
        halt_i = 1'b1;
        repeat (3) begin
            step();
            chk("halt stall stb", {63'd0, fetch_stb_o}, 64'd1);
            chk("halt stall adr", fetch_adr_o, 64'h40);
        end
        instr_ready_i = 1'b0;
        ack_en        = 1'b1;
        step();
        $display("halt seq: valid=%0b ipc=%h stb=%0b", instr_valid_o, instr_pc_o, fetch_stb_o);
        chk("halt completes valid", {63'd0, instr_valid_o}, 64'd1);
        chk("halt completes ipc", instr_pc_o, 64'h40);
        held = instr_o;
        chk("halt completes instr", held, rom(64'h40));
        repeat (2) step();
        chk("halt held instr", instr_o, rom(64'h40));
        instr_ready_i = 1'b1;
        step();
        chk("halt drained", {63'd0, instr_valid_o}, 64'd0);
        stb_seen = 0;
        repeat (5) begin
            step();
            if (fetch_stb_o) stb_seen++;
        end
        chk("halt no stb", 64'(stb_seen), 64'd0);
        halt_i = 1'b0;
        wait_stb("halt release", 8);
        chk("halt release adr", fetch_adr_o, 64'h48);
        step();

        // PC wraps to zero past the top of the address space.
        pulse_redirect(64'hFFFF_FFFF_FFFF_FFF8);
        wait_stb("wrap issue", 8);
        chk("wrap adr top", fetch_adr_o, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        step();
        wait_stb("wrap next", 8);
        chk("wrap adr zero", fetch_adr_o, 64'h00);
        step();

        // Reset in the middle of a stalled request.
        ack_en = 1'b0;
        pulse_redirect(64'h80);
        wait_stb("rst issue", 8);
        chk("rst pre adr", fetch_adr_o, 64'h80);
        rst_i = 1'b1;
        #1;
        $display("rst seq: stb=%0b adr=%h valid=%0b", fetch_stb_o, fetch_adr_o, instr_valid_o);
        chk("rst async stb", {63'd0, fetch_stb_o}, 64'd0);
        chk("rst async cyc", {63'd0, fetch_cyc_o}, 64'd0);
        chk("rst async adr", fetch_adr_o, 64'h00);
        ack_en = 1'b1;
        step();
        chk("rst no capture", {63'd0, instr_valid_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
        chk("rst restart stb", {63'd0, fetch_stb_o}, 64'd1);
        chk("rst restart adr", fetch_adr_o, 64'h00);
        step();
        chk("rst restart ipc", instr_pc_o, 64'h00);
        chk("rst restart instr", instr_o, 64'h0204000000200420);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
